// File: rtl/stopwatch_pkg.sv
// Shared types and default sizing for the stopwatch controller slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2,
        SW_LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned SW_TICK_DIV_DEF = 4;
    localparam int unsigned SW_WIDTH_DEF    = 8;

endpackage

// File: rtl/sw_tick_prescaler.sv
// Divides clk down to a count-increment strobe; holds phase while disabled.
module sw_tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = SW_TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] phase;

    // Phase counter: clear wins, otherwise advance and wrap only while enabled.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    // Strobe in the last phase of an enabled interval; consumer registers it.
    always_comb begin
        tick = enable && (phase == LAST);
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM with elapsed counter, lap hold register and overflow flag.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = SW_TICK_DIV_DEF,
    parameter int unsigned WIDTH    = SW_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             lap_reset,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] display,
    output logic             running,
    output logic             lap_active,
    output logic             tick,
    output logic             overflow
);

    sw_state_t        state, state_nxt;
    logic             pre_tick, pre_enable, pre_clear;
    logic [WIDTH-1:0] lap_q, lap_nxt, count_nxt, display_nxt;
    logic             overflow_nxt;

    // Prescaler control kept apart from the FSM block so the combinational
    // tick feedback does not form a loop through one process.
    always_comb begin
        pre_enable = (state == SW_RUN) || (state == SW_LAP);
        pre_clear  = (state == SW_PAUSE) && lap_reset && !start_stop;
    end

    sw_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (pre_enable),
        .clear  (pre_clear),
        .tick   (pre_tick)
    );

    // Mode register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath next values; start_stop beats lap_reset.
    always_comb begin
        state_nxt    = state;
        count_nxt    = pre_tick ? count + WIDTH'(1) : count;
        overflow_nxt = overflow || (pre_tick && (count == '1));
        lap_nxt      = lap_q;
        unique case (state)
            SW_IDLE: begin
                if (start_stop) state_nxt = SW_RUN;
            end
            SW_RUN: begin
                if (start_stop) begin
                    state_nxt = SW_PAUSE;
                end else if (lap_reset) begin
                    state_nxt = SW_LAP;
                    lap_nxt   = count_nxt;
                end
            end
            SW_LAP: begin
                if (start_stop) begin
                    state_nxt = SW_PAUSE;
                end else if (lap_reset) begin
                    state_nxt = SW_RUN;
                end
            end
            SW_PAUSE: begin
                if (start_stop) begin
                    state_nxt = SW_RUN;
                end else if (lap_reset) begin
                    state_nxt    = SW_IDLE;
                    count_nxt    = '0;
                    lap_nxt      = '0;
                    overflow_nxt = 1'b0;
                end
            end
            default: state_nxt = SW_IDLE;
        endcase
        display_nxt = (state_nxt == SW_LAP) ? lap_nxt : count_nxt;
    end

    // Registered outputs follow the state being entered on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            display    <= '0;
            lap_q      <= '0;
            overflow   <= 1'b0;
            tick       <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            count      <= count_nxt;
            display    <= display_nxt;
            lap_q      <= lap_nxt;
            overflow   <= overflow_nxt;
            tick       <= pre_tick;
            running    <= (state_nxt == SW_RUN) || (state_nxt == SW_LAP);
            lap_active <= (state_nxt == SW_LAP);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: expectations queued by stimulus, checked by a monitor.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       lap_reset;
  logic [7:0] count;
  logic [7:0] display;
  logic       running;
  logic       lap_active;
  logic       tick;
  logic       overflow;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t sb[$];

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .WIDTH    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .count      (count),
    .display    (display),
    .running    (running),
    .lap_active (lap_active),
    .tick       (tick),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int unsigned dt, input string nm, input int c, input int d,
                           input bit r, input bit l, input bit t, input bit o);
    exp_t e;
    e.cyc  = cyc + dt;
    e.name = nm;
    e.v    = {8'(c), 8'(d), r, l, t, o};
    sb.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit ss, input bit lr);
    start_stop = ss;
    lap_reset  = lr;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] act;
    act = {count, display, running, lap_active, tick, overflow};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc != cyc || act !== e.v) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): got cnt=%0d disp=%0d run=%0b lap=%0b tick=%0b ovf=%0b, want cnt=%0d disp=%0d run=%0b lap=%0b tick=%0b ovf=%0b",
                 e.name, cyc, e.cyc, act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                 e.v[19:12], e.v[11:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_at(0, "reset_state", 0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({count, display, running, lap_active, tick, overflow} !== 20'h0) begin
      n_bad++;
      $display("FAIL direct_reset: got cnt=%0d disp=%0d run=%0b lap=%0b tick=%0b ovf=%0b, want all 0",
               count, display, running, lap_active, tick, overflow);
    end
    idle(1);

    // 1: start latency and steady counting
    pulse(1, 0);
    expect_at(0,  "run_entry",   0, 0, 1, 0, 0, 0);
    n_vec++;
    if (running !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_run_entry: got running=%0b, want 1", running);
    end
    expect_at(3,  "pre_first",   0, 0, 1, 0, 0, 0);
    expect_at(4,  "first_tick",  1, 1, 1, 0, 1, 0);
    expect_at(5,  "after_first", 1, 1, 1, 0, 0, 0);
    expect_at(20, "count5",      5, 5, 1, 0, 1, 0);
    idle(20);

    // 2: lap captured on a tick edge, held while counting, then released
    idle(19);
    pulse(0, 1);
    expect_at(0,  "lap_capture", 10, 10, 1, 1, 1, 0);
    n_vec++;
    if (lap_active !== 1'b1 || display !== 8'd10) begin
      n_bad++;
      $display("FAIL direct_lap_capture: got lap=%0b disp=%0d, want lap=1 disp=10", lap_active, display);
    end
    expect_at(8,  "lap_mid",     12, 10, 1, 1, 1, 0);
    expect_at(16, "lap_hold",    14, 10, 1, 1, 1, 0);
    idle(16);
    pulse(0, 1);
    expect_at(0, "lap_release", 14, 14, 1, 0, 0, 0);

    // clear to IDLE from PAUSE
    pulse(1, 0);
    expect_at(0, "pause14", 14, 14, 0, 0, 0, 0);
    pulse(0, 1);
    expect_at(0, "clear_idle", 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (count !== 8'd0 || display !== 8'd0) begin
      n_bad++;
      $display("FAIL direct_clear_idle: got cnt=%0d disp=%0d, want 0 0", count, display);
    end

    // 3: pause with partial interval preserved
    pulse(1, 0);
    idle(29);
    pulse(1, 0);
    expect_at(0,  "stop7",       7, 7, 0, 0, 0, 0);
    expect_at(25, "pause_mid",   7, 7, 0, 0, 0, 0);
    expect_at(50, "pause_end",   7, 7, 0, 0, 0, 0);
    idle(50);
    pulse(1, 0);
    expect_at(0, "restart",     7, 7, 1, 0, 0, 0);
    expect_at(1, "restart_p3",  7, 7, 1, 0, 0, 0);
    expect_at(2, "resume_tick", 8, 8, 1, 0, 1, 0);
    idle(2);
    pulse(1, 0);
    expect_at(0, "stop8", 8, 8, 0, 0, 0, 0);
    pulse(0, 1);
    expect_at(0, "idle_again", 0, 0, 0, 0, 0, 0);

    // 4: wrap and sticky overflow
    pulse(1, 0);
    expect_at(1020, "at_255",   255, 255, 1, 0, 1, 0);
    expect_at(1023, "pre_wrap", 255, 255, 1, 0, 0, 0);
    expect_at(1024, "wrap",     0,   0,   1, 0, 1, 1);
    idle(1024);
    pulse(1, 0);
    expect_at(0, "ovf_pause", 0, 0, 0, 0, 0, 1);
    idle(5);
    pulse(1, 0);
    expect_at(0, "ovf_restart", 0, 0, 1, 0, 0, 1);
    expect_at(3, "ovf_sticky",  1, 1, 1, 0, 1, 1);
    idle(3);

    // 5: simultaneous buttons, start_stop wins in RUN and PAUSE
    pulse(1, 1);
    expect_at(0, "both_run", 1, 1, 0, 0, 0, 1);
    pulse(1, 1);
    expect_at(0, "both_pause",  1, 1, 1, 0, 0, 1);
    expect_at(3, "both_resume", 2, 2, 1, 0, 1, 1);
    idle(3);
    pulse(1, 0);
    expect_at(0, "stop2", 2, 2, 0, 0, 0, 1);
    pulse(0, 1);
    expect_at(0, "ovf_clear", 0, 0, 0, 0, 0, 0);

    // 6: reset while in LAP at the last prescaler phase
    pulse(1, 0);
    idle(132);
    pulse(0, 1);
    expect_at(0, "lap33", 33, 33, 1, 1, 0, 0);
    idle(2);
    reset      = 1'b1;
    start_stop = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    start_stop = 1'b0;
    expect_at(0, "reset_in_lap", 0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({count, display, running, lap_active, tick, overflow} !== 20'h0) begin
      n_bad++;
      $display("FAIL direct_reset_in_lap: got cnt=%0d disp=%0d run=%0b lap=%0b tick=%0b ovf=%0b, want all 0",
               count, display, running, lap_active, tick, overflow);
    end
    expect_at(5, "reset_idle",   0, 0, 0, 0, 0, 0);
    idle(5);
    pulse(1, 0);
    expect_at(0, "rerun",      0, 0, 1, 0, 0, 0);
    expect_at(3, "rerun_pre",  0, 0, 1, 0, 0, 0);
    expect_at(4, "rerun_tick", 1, 1, 1, 0, 1, 0);
    idle(6);

    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: got unchecked, want checked at cyc %0d", e.name, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controls a stopwatch elapsed-time counter from two single-cycle button pulses: start_stop and lap_reset.
- Contains the prescaler, the elapsed counter, a lap/display hold register and the mode FSM.
- Sits between the debounced button front end and the display driver.

Parameters:
TICK_DIV, 4, clk cycles per count increment; must be >= 2.
WIDTH, 8, width of the elapsed count and the display value.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high; clock clk.
start_stop  input  1  single-cycle pulse; start or stop counting.
lap_reset  input  1  single-cycle pulse; lap capture or release while running, clear while paused.
count  output  WIDTH  live elapsed count.
display  output  WIDTH  value shown: the live count, or the frozen lap value in LAP.
running  output  1  high in RUN and LAP.
lap_active  output  1  high in LAP.
tick  output  1  one-cycle pulse in the cycle count increments.
overflow  output  1  sticky; set on count wrap.

Behaviour:
- Reset: the FSM goes to IDLE. count, display, prescaler and lap register are 0. running, lap_active, tick and overflow are 0.
- All outputs are registered. Decisions use the current state and the current-cycle inputs.
- States and transitions (all updates take effect at the edge):
  - IDLE: start_stop -> RUN. lap_reset is ignored.
  - RUN: start_stop -> PAUSE. lap_reset -> LAP, capturing the lap register from the count value as incremented in the same edge.
  - LAP: start_stop -> PAUSE and display returns to the live count. lap_reset -> RUN and display is released.
  - PAUSE: start_stop -> RUN. lap_reset -> IDLE, clearing count, prescaler, lap register and overflow.
- Simultaneous start_stop and lap_reset: start_stop wins and lap_reset is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 while the current state is RUN or LAP, wrapping to 0.
  - Holds its value in PAUSE, so a partial interval is preserved.
  - Is 0 in IDLE.
- Tick: fires when the current state is RUN or LAP and the prescaler equals TICK_DIV-1. A tick on the same edge as RUN->PAUSE still increments count. Entering RUN does not tick on the entry edge.
- Latency: after start_stop from IDLE, the first increment (count=1, tick=1) is visible exactly TICK_DIV edges after the edge that entered RUN.
- Arithmetic: count increments modulo 2^WIDTH. On the tick where count == 2^WIDTH-1, count becomes 0 and overflow is set. overflow clears only in IDLE or on reset.
- Display:
  - Equals count, updated on the same edge, in every state except LAP.
  - In LAP it equals the lap register and does not change while count keeps incrementing.
- Reset mid-operation, in any state and at any prescaler phase: next state is IDLE with all values as at reset. Button pulses in the reset cycle are ignored.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum sw_state_t {SW_IDLE, SW_RUN, SW_PAUSE, SW_LAP}, 2 bits;
  - the default constants SW_TICK_DIV_DEF = 4 and SW_WIDTH_DEF = 8.
- One sub-module, sw_tick_prescaler:
  - parameter TICK_DIV; inputs clk, reset, enable, clear; output tick;
  - holds its value when enable is low; clear has priority.
- The FSM, count, lap register and overflow logic stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4, WIDTH=8):
1. Reset, then a start_stop pulse -> running=1 the next cycle; tick and count=1 exactly 4 edges after RUN entry; count=5 after 20 edges.
2. Run to count=10, then lap_reset -> lap_active=1 and display holds 10 while count reaches 14 over 16 cycles. A second lap_reset -> display=14 and lap_active=0.
3. Run to count=7, stop with prescaler=2, wait 50 cycles, then start -> count stays 7 throughout the pause and reaches 8 two edges after restart. Stop again, then lap_reset -> IDLE with count=0 and display=0.
4. Run to 255 (1020 edges) -> the next tick gives count=0 and overflow=1. overflow stays 1 through pause and restart, and clears only on returning to IDLE.
5. start_stop and lap_reset in the same cycle, in RUN and in PAUSE -> only the start_stop transition occurs (RUN->PAUSE, PAUSE->RUN) and count is unaffected by lap_reset.
6. Assert reset in LAP with count=33 and prescaler=3 -> all outputs 0 the next cycle. A start_stop pulse in the reset cycle is ignored and the state stays IDLE.
